// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the single-SRAM read/write port arbiter.
// Holds the FSM state encoding, the mem_rw polarity and the grant encoding.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic {
    GNT_R = 1'b0,
    GNT_W = 1'b1
  } grant_e;

endpackage

// File: rtl/sram_arb_age_ctr.sv
// Write-starvation counter: counts IDLE cycles in which W waited unaccepted,
// saturating at WR_MAX_WAIT, and raises force_w once the limit is reached.
module sram_arb_age_ctr #(
  parameter int WR_MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic force_w
);

  localparam int CW = $clog2(WR_MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WR_MAX_WAIT);

  logic [CW-1:0] wait_cnt;

  // Clearing on a W accept takes precedence over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (inc && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign force_w = (wait_cnt == CNT_MAX);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one sram_ctrl between a capture-side write port and a VGA read port,
// one transaction in flight. Define ARB_STARVE_GUARD_EN to bound write starvation.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int WR_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_valid,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ready,
  output logic              w_done,
  input  logic              r_valid,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  output logic              r_dvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_start_n,
  output logic              mem_rw,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              timeout_err
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  arb_state_e      state, next_state;
  grant_e          grant;
  logic [TO_W-1:0] to_cnt;
  logic            force_w;

`ifdef ARB_STARVE_GUARD_EN
  sram_arb_age_ctr #(
    .WR_MAX_WAIT(WR_MAX_WAIT)
  ) u_age_ctr (
    .clk    (clk),
    .reset  (reset),
    .inc    ((state == IDLE) && w_valid && !w_ready),
    .clr    (w_ready),
    .force_w(force_w)
  );
`else
  // Strict R-over-W priority; the write-wait limit has no effect in this build.
  assign force_w = 1'b0 && (WR_MAX_WAIT > 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    grant       = GNT_R;
    r_ready     = 1'b0;
    w_ready     = 1'b0;
    r_dvalid    = 1'b0;
    w_done      = 1'b0;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        if (force_w && w_valid) begin
          grant = GNT_W;
        end else if (r_valid) begin
          grant = GNT_R;
        end else if (w_valid) begin
          grant = GNT_W;
        end
        r_ready = !reset && r_valid && (grant == GNT_R);
        w_ready = !reset && w_valid && (grant == GNT_W);
        if (r_ready || w_ready) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        next_state = BUSY;
      end
      BUSY: begin
        if (mem_ready) begin
          next_state = DONE;
        end else if (to_cnt == TO_LAST) begin
          next_state  = IDLE;
          timeout_err = 1'b1;
        end
      end
      DONE: begin
        r_dvalid   = (mem_rw == RW_READ);
        w_done     = (mem_rw == RW_WRITE);
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request is latched at accept and held untouched until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rw    <= RW_READ;
    end else if (r_ready) begin
      mem_addr <= r_addr;
      mem_rw   <= RW_READ;
    end else if (w_ready) begin
      mem_addr  <= w_addr;
      mem_wdata <= w_data;
      mem_rw    <= RW_WRITE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == ISSUE) begin
      to_cnt <= '0;
    end else if (state == BUSY) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
    end else if ((state == BUSY) && mem_ready && (mem_rw == RW_READ)) begin
      r_data <= mem_rdata;
    end
  end

  assign mem_start_n = (state != ISSUE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter; the bench plays sram_ctrl
// by driving mem_ready/mem_rdata by hand, or as an inverting memory model.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_valid;
  logic [15:0] w_addr;
  logic [15:0] w_data;
  logic        w_ready;
  logic        w_done;
  logic        r_valid;
  logic [15:0] r_addr;
  logic        r_ready;
  logic [15:0] r_data;
  logic        r_dvalid;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_start_n;
  logic        mem_rw;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        timeout_err;

  logic        model_en;
  logic [15:0] rdata_drv;
  logic [15:0] exp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  assign mem_rdata = model_en ? ~mem_addr : rdata_drv;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .TIMEOUT_CYC(64),
    .WR_MAX_WAIT(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .w_valid    (w_valid),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .w_ready    (w_ready),
    .w_done     (w_done),
    .r_valid    (r_valid),
    .r_addr     (r_addr),
    .r_ready    (r_ready),
    .r_data     (r_data),
    .r_dvalid   (r_dvalid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_start_n(mem_start_n),
    .mem_rw     (mem_rw),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  // Inputs change just after a falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; r_valid = 1'b1; w_valid = 1'b1;
    r_addr = 16'h1111; w_addr = 16'h2222; w_data = 16'h3333;
    next_cycle(); #1;
    n_checks++;
    if (r_ready !== 1'b0 || w_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_ready: got r=%b w=%b, expected 0 0", r_ready, w_ready);
    end
    n_checks++;
    if (mem_start_n !== 1'b1 || mem_rw !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_ctrl: got start_n=%b rw=%b, expected 1 1", mem_start_n, mem_rw);
    end
    n_checks++;
    if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || r_data !== 16'h0) begin
      n_fail++; $display("[TB] FAIL reset_data: got addr=%h wdata=%h rdata=%h, expected 0", mem_addr, mem_wdata, r_data);
    end
    n_checks++;
    if (busy !== 1'b0 || r_dvalid !== 1'b0 || w_done !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags: got busy=%b dv=%b wd=%b to=%b, expected 0", busy, r_dvalid, w_done, timeout_err);
    end
    next_cycle();
    reset = 1'b0; r_valid = 1'b0; w_valid = 1'b0;
  endtask

  task automatic test_single_read();
    next_cycle();
    r_valid = 1'b1; r_addr = 16'h0123; mem_ready = 1'b0; rdata_drv = 16'hBEEF;
    #1;
    n_checks++;
    if (r_ready !== 1'b1 || w_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL read_accept: got r_ready=%b w_ready=%b, expected 1 0", r_ready, w_ready);
    end
    next_cycle();
    r_valid = 1'b0;
    #1;
    n_checks++;
    if (mem_start_n !== 1'b0 || mem_rw !== 1'b1 || mem_addr !== 16'h0123) begin
      n_fail++; $display("[TB] FAIL read_issue: got start_n=%b rw=%b addr=%h, expected 0 1 0123", mem_start_n, mem_rw, mem_addr);
    end
    for (int k = 0; k < 2; k++) begin
      next_cycle(); #1;
      n_checks++;
      if (mem_start_n !== 1'b1 || busy !== 1'b1 || r_dvalid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL read_busy: got start_n=%b busy=%b dv=%b, expected 1 1 0", mem_start_n, busy, r_dvalid);
      end
    end
    next_cycle();
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (r_dvalid !== 1'b0 || mem_addr !== 16'h0123) begin
      n_fail++; $display("[TB] FAIL read_ready_cycle: got dv=%b addr=%h, expected 0 0123", r_dvalid, mem_addr);
    end
    next_cycle();
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (r_dvalid !== 1'b1 || r_data !== 16'hBEEF || w_done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL read_done: got dv=%b data=%h wd=%b, expected 1 beef 0", r_dvalid, r_data, w_done);
    end
    next_cycle(); #1;
    n_checks++;
    if (r_dvalid !== 1'b0 || busy !== 1'b0 || r_data !== 16'hBEEF) begin
      n_fail++; $display("[TB] FAIL read_after: got dv=%b busy=%b data=%h, expected 0 0 beef", r_dvalid, busy, r_data);
    end
  endtask

  task automatic test_single_write();
    next_cycle();
    w_valid = 1'b1; w_addr = 16'h00FF; w_data = 16'h0ABC;
    #1;
    n_checks++;
    if (w_ready !== 1'b1 || r_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL write_accept: got w_ready=%b r_ready=%b, expected 1 0", w_ready, r_ready);
    end
    next_cycle();
    w_valid = 1'b0;
    #1;
    n_checks++;
    if (mem_start_n !== 1'b0 || mem_rw !== 1'b0 || mem_wdata !== 16'h0ABC || mem_addr !== 16'h00FF) begin
      n_fail++; $display("[TB] FAIL write_issue: got start_n=%b rw=%b wdata=%h addr=%h, expected 0 0 0abc 00ff", mem_start_n, mem_rw, mem_wdata, mem_addr);
    end
    next_cycle();
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (mem_start_n !== 1'b1 || mem_rw !== 1'b0 || mem_wdata !== 16'h0ABC) begin
      n_fail++; $display("[TB] FAIL write_busy: got start_n=%b rw=%b wdata=%h, expected 1 0 0abc", mem_start_n, mem_rw, mem_wdata);
    end
    next_cycle();
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (w_done !== 1'b1 || r_dvalid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL write_done: got wd=%b dv=%b, expected 1 0", w_done, r_dvalid);
    end
    next_cycle(); #1;
    n_checks++;
    if (w_done !== 1'b0 || busy !== 1'b0 || r_data !== 16'hBEEF) begin
      n_fail++; $display("[TB] FAIL write_after: got wd=%b busy=%b rdata=%h, expected 0 0 beef", w_done, busy, r_data);
    end
  endtask

  // Both ports request every cycle; sram_ctrl answers at once, so accepts fall every 4 cycles.
  task automatic test_priority();
    int  w_acc;
    logic exp_w;
    w_acc = 0;
    rdata_drv = 16'h5A5A;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      r_valid = 1'b1; w_valid = 1'b1; mem_ready = 1'b1;
      r_addr = 16'h0400; w_addr = 16'h0500; w_data = 16'h0600;
      #1;
      if (w_ready === 1'b1) w_acc++;
      if (i % 4 == 0) begin
`ifdef ARB_STARVE_GUARD_EN
        exp_w = (i == 32);
`else
        exp_w = 1'b0;
`endif
        n_checks++;
        if (r_ready !== !exp_w || w_ready !== exp_w) begin
          n_fail++; $display("[TB] FAIL prio_grant_%0d: got r=%b w=%b, expected r=%b w=%b", i, r_ready, w_ready, !exp_w, exp_w);
        end
      end else begin
        n_checks++;
        if (r_ready !== 1'b0 || w_ready !== 1'b0) begin
          n_fail++; $display("[TB] FAIL prio_idle_%0d: got r=%b w=%b, expected 0 0", i, r_ready, w_ready);
        end
      end
    end
    next_cycle();
    r_valid = 1'b0; w_valid = 1'b0; mem_ready = 1'b0;
    #1;
    n_checks++;
`ifdef ARB_STARVE_GUARD_EN
    if (w_acc !== 1) begin
      n_fail++; $display("[TB] FAIL prio_w_count: got %0d, expected 1", w_acc);
    end
`else
    if (w_acc !== 0) begin
      n_fail++; $display("[TB] FAIL prio_w_count: got %0d, expected 0", w_acc);
    end
`endif
    n_checks++;
    if (busy !== 1'b0 || r_data !== 16'h5A5A) begin
      n_fail++; $display("[TB] FAIL prio_end: got busy=%b data=%h, expected 0 5a5a", busy, r_data);
    end
    exp_rdata = 16'h5A5A;
  endtask

  task automatic test_timeout();
    next_cycle();
    r_valid = 1'b1; r_addr = 16'h0200; mem_ready = 1'b0; rdata_drv = 16'hDEAD;
    #1;
    n_checks++;
    if (r_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL to_accept: got %b, expected 1", r_ready);
    end
    next_cycle();
    r_valid = 1'b0;
    #1;
    n_checks++;
    if (mem_start_n !== 1'b0) begin
      n_fail++; $display("[TB] FAIL to_issue: got start_n=%b, expected 0", mem_start_n);
    end
    for (int k = 1; k <= 64; k++) begin
      next_cycle(); #1;
      n_checks++;
      if (timeout_err !== (k == 64) || busy !== 1'b1 || r_dvalid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL to_wait_%0d: got to=%b busy=%b dv=%b, expected %b 1 0", k, timeout_err, busy, r_dvalid, (k == 64));
      end
    end
    next_cycle(); #1;
    n_checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b0 || r_dvalid !== 1'b0 || r_data !== exp_rdata) begin
      n_fail++; $display("[TB] FAIL to_after: got busy=%b to=%b dv=%b data=%h, expected 0 0 0 %h", busy, timeout_err, r_dvalid, r_data, exp_rdata);
    end
    next_cycle();
    r_valid = 1'b1; r_addr = 16'h0300; mem_ready = 1'b1; rdata_drv = 16'h1234;
    #1;
    n_checks++;
    if (r_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL to_next_accept: got %b, expected 1", r_ready);
    end
    next_cycle();
    r_valid = 1'b0;
    next_cycle();
    next_cycle(); #1;
    n_checks++;
    if (r_dvalid !== 1'b1 || r_data !== 16'h1234) begin
      n_fail++; $display("[TB] FAIL to_next_done: got dv=%b data=%h, expected 1 1234", r_dvalid, r_data);
    end
    next_cycle();
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    next_cycle();
    r_valid = 1'b1; r_addr = 16'h0777; mem_ready = 1'b0; rdata_drv = 16'hCAFE;
    next_cycle();
    r_valid = 1'b0;
    next_cycle();
    next_cycle(); #1;
    n_checks++;
    if (busy !== 1'b1 || mem_addr !== 16'h0777) begin
      n_fail++; $display("[TB] FAIL rst_mid_busy: got busy=%b addr=%h, expected 1 0777", busy, mem_addr);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || mem_start_n !== 1'b1 || mem_rw !== 1'b1 || mem_addr !== 16'h0 || r_data !== 16'h0) begin
      n_fail++; $display("[TB] FAIL rst_mid_async: got busy=%b start_n=%b rw=%b addr=%h data=%h, expected 0 1 1 0 0", busy, mem_start_n, mem_rw, mem_addr, r_data);
    end
    next_cycle();
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (r_dvalid !== 1'b0 || w_done !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_mid_pulse: got dv=%b wd=%b to=%b, expected 0 0 0", r_dvalid, w_done, timeout_err);
    end
    next_cycle();
    reset = 1'b0;
    next_cycle(); #1;
    n_checks++;
    if (r_dvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_mid_release: got dv=%b busy=%b, expected 0 0", r_dvalid, busy);
    end
    next_cycle();
    r_valid = 1'b1; r_addr = 16'h0456; rdata_drv = 16'h0789;
    #1;
    n_checks++;
    if (r_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL rst_mid_new_accept: got %b, expected 1", r_ready);
    end
    next_cycle();
    r_valid = 1'b0;
    #1;
    n_checks++;
    if (mem_start_n !== 1'b0 || mem_addr !== 16'h0456) begin
      n_fail++; $display("[TB] FAIL rst_mid_new_issue: got start_n=%b addr=%h, expected 0 0456", mem_start_n, mem_addr);
    end
    next_cycle();
    next_cycle(); #1;
    n_checks++;
    if (r_dvalid !== 1'b1 || r_data !== 16'h0789) begin
      n_fail++; $display("[TB] FAIL rst_mid_new_done: got dv=%b data=%h, expected 1 0789", r_dvalid, r_data);
    end
    next_cycle();
    mem_ready = 1'b0;
  endtask

  // The memory model returns ~addr, so every read result identifies its own address.
  task automatic test_back_to_back();
    logic [15:0] a;
    model_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      a = 16'h1000 + 16'(i / 4);
      r_valid = 1'b1; r_addr = a; mem_ready = 1'b1;
      #1;
      n_checks++;
      if (r_ready !== (i % 4 == 0)) begin
        n_fail++; $display("[TB] FAIL b2b_accept_%0d: got %b, expected %b", i, r_ready, (i % 4 == 0));
      end
      if (i % 4 == 3) begin
        n_checks++;
        if (r_dvalid !== 1'b1 || r_data !== ~a) begin
          n_fail++; $display("[TB] FAIL b2b_data_%0d: got dv=%b data=%h, expected 1 %h", i, r_dvalid, r_data, ~a);
        end
      end
    end
    next_cycle();
    r_valid = 1'b0; mem_ready = 1'b0; model_en = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_end: got busy=%b, expected 0", busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    w_valid = 1'b0; w_addr = '0; w_data = '0;
    r_valid = 1'b0; r_addr = '0;
    mem_ready = 1'b0; model_en = 1'b0; rdata_drv = '0; exp_rdata = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_priority();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion within 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
